// File: rtl/multiword_carry_adder.sv
`default_nettype none
// ============================================================================
// Module      : multiword_carry_adder
// Description : Multi-precision add/subtract engine. A TOTAL_W-bit operation
//               is processed as NUM_CHUNKS chunks of CHUNK_W bits, one chunk
//               per clock, with a selectable initial carry (zero, one,
//               external, or chained from the previous operation's carry-out).
//               Produces sum/difference, carry-out and signed overflow.
// Ports       : clk, rst      - clock, synchronous active-high reset
//               start/ready   - request / accept handshake
//               mode_sel      - 0: carry mode C_INIT, 1: carry mode c_mode
//               c_mode        - 00 zero, 01 one, 10 cin, 11 chained carry
//               sub, cin      - subtract select, external carry-in
//               op_a, op_b    - operands (sampled on accept)
//               result, cout, ovf, valid - outputs, valid pulses on update
// Revision    : 1.0 - initial release
// ============================================================================
module multiword_carry_adder #(
    parameter int         CHUNK_W    = 8,
    parameter int         NUM_CHUNKS = 4,
    parameter logic [1:0] C_INIT     = 2'b00
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            start,
    output logic                            ready,
    input  logic                            mode_sel,
    input  logic [1:0]                      c_mode,
    input  logic                            sub,
    input  logic                            cin,
    input  logic [CHUNK_W*NUM_CHUNKS-1:0]   op_a,
    input  logic [CHUNK_W*NUM_CHUNKS-1:0]   op_b,
    output logic [CHUNK_W*NUM_CHUNKS-1:0]   result,
    output logic                            cout,
    output logic                            ovf,
    output logic                            valid
);

    localparam int C_TOTAL_W = CHUNK_W * NUM_CHUNKS;
    localparam int C_IDX_W   = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;

    localparam logic [C_IDX_W-1:0] C_LAST_IDX = C_IDX_W'(NUM_CHUNKS - 1);

    localparam logic [1:0] C_ST_IDLE = 2'd0;
    localparam logic [1:0] C_ST_RUN  = 2'd1;
    localparam logic [1:0] C_ST_DONE = 2'd2;

    logic [1:0]           r_state;
    logic [1:0]           w_state_next;

    // Operand registers shift right one chunk per RUN cycle, so the active
    // chunk is always in the low CHUNK_W bits.
    logic [C_TOTAL_W-1:0] r_a;
    logic [C_TOTAL_W-1:0] r_b;
    logic                 r_carry;
    logic [C_IDX_W-1:0]   r_idx;
    logic [C_TOTAL_W-1:0] r_shadow;
    logic                 r_last_cout;

    logic                 w_accept;
    logic [1:0]           w_mode;
    logic                 w_c0;
    logic [CHUNK_W:0]     w_chunk_sum;
    logic [CHUNK_W-1:0]   w_chunk_out;
    logic                 w_chunk_cout;
    logic                 w_msb_cin;
    logic                 w_last;
    logic [C_TOTAL_W-1:0] w_shadow_next;

    assign ready    = (r_state != C_ST_RUN);
    assign w_accept = start & ready;
    assign w_mode   = mode_sel ? c_mode : C_INIT;
    assign w_last   = (r_idx == C_LAST_IDX);

    // Initial carry. In DONE the finishing operation's carry-out is already
    // in r_last_cout (loaded on the final RUN edge), so a chained start in
    // DONE sees the fresh value without extra forwarding logic.
    always_comb begin
        w_c0 = 1'b0;
        case (w_mode)
            2'b00:   w_c0 = sub;
            2'b01:   w_c0 = ~sub;
            2'b10:   w_c0 = cin;
            2'b11:   w_c0 = r_last_cout;
            default: w_c0 = 1'b0;
        endcase
    end

    assign w_chunk_sum  = {1'b0, r_a[CHUNK_W-1:0]} + {1'b0, r_b[CHUNK_W-1:0]}
                        + {{CHUNK_W{1'b0}}, r_carry};
    assign w_chunk_out  = w_chunk_sum[CHUNK_W-1:0];
    assign w_chunk_cout = w_chunk_sum[CHUNK_W];

    // Carry into the top bit of the chunk recovered from the sum bit:
    // s = a ^ b ^ c  =>  c = s ^ a ^ b. Only meaningful on the final chunk.
    assign w_msb_cin = w_chunk_out[CHUNK_W-1] ^ r_a[CHUNK_W-1] ^ r_b[CHUNK_W-1];

    // New chunk enters at the top; after NUM_CHUNKS cycles chunk 0 sits at
    // the bottom of the shadow.
    assign w_shadow_next = (r_shadow >> CHUNK_W)
                         | (C_TOTAL_W'(w_chunk_out) << (C_TOTAL_W - CHUNK_W));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= C_ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            C_ST_IDLE: if (start)  w_state_next = C_ST_RUN;
            C_ST_RUN:  if (w_last) w_state_next = C_ST_DONE;
            C_ST_DONE: w_state_next = start ? C_ST_RUN : C_ST_IDLE;
            default:   w_state_next = C_ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a         <= '0;
            r_b         <= '0;
            r_carry     <= 1'b0;
            r_idx       <= '0;
            r_shadow    <= '0;
            r_last_cout <= 1'b0;
            result      <= '0;
            cout        <= 1'b0;
            ovf         <= 1'b0;
            valid       <= 1'b0;
        end else begin
            valid <= 1'b0;
            if (w_accept) begin
                r_a     <= op_a;
                r_b     <= sub ? ~op_b : op_b;
                r_carry <= w_c0;
                r_idx   <= '0;
            end else if (r_state == C_ST_RUN) begin
                r_a      <= r_a >> CHUNK_W;
                r_b      <= r_b >> CHUNK_W;
                r_carry  <= w_chunk_cout;
                r_shadow <= w_shadow_next;
                r_idx    <= r_idx + 1'b1;
                // Publish on the final chunk edge so outputs and valid are
                // visible during the DONE cycle.
                if (w_last) begin
                    result      <= w_shadow_next;
                    cout        <= w_chunk_cout;
                    ovf         <= w_msb_cin ^ w_chunk_cout;
                    valid       <= 1'b1;
                    r_last_cout <= w_chunk_cout;
                end
            end
        end
    end

endmodule
`default_nettype wire
